// File: rtl/div_req_ctrl_pkg.sv
// Shared definitions for the divider request controller: op codes,
// handshake levels, FSM state encoding and the request decode helper.
package div_req_ctrl_pkg;

    // ALU op codes of the two divide instructions
    localparam logic [7:0] DIV_CONTROL  = 8'b0001_1010;
    localparam logic [7:0] DIVU_CONTROL = 8'b0001_1011;

    // Handshake levels on the divider interface
    localparam logic DIV_START = 1'b1;
    localparam logic DIV_STOP  = 1'b0;
    localparam logic DIV_READY = 1'b1;

    // Controller states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BUSY   = 2'd1,
        ST_DONE   = 2'd2,
        ST_CANCEL = 2'd3
    } div_state_e;

    // True for either divide flavour
    function automatic logic is_div_op(input logic [7:0] op);
        return (op == DIV_CONTROL) || (op == DIVU_CONTROL);
    endfunction

endpackage

// File: rtl/div_req_ctrl.sv
// EX-stage initiator for the multi-cycle divider. Issues DIV/DIVU, holds
// start until ready, stalls EX meanwhile, and writes {remainder,quotient}
// into HI/LO. Flush or a watchdog timeout annuls the operation and drains
// the divider for two cycles before accepting a new request.
module div_req_ctrl
    import div_req_ctrl_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 48
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid_i,
    input  logic [7:0]  ex_op_i,
    input  logic [31:0] ex_src1_i,
    input  logic [31:0] ex_src2_i,
    input  logic        flush_i,
    input  logic        stall_i,
    output logic        stall_req_o,
    output logic        div_start_o,
    output logic        div_annul_o,
    output logic [7:0]  div_op_o,
    output logic [31:0] div_opdata1_o,
    output logic [31:0] div_opdata2_o,
    input  logic [63:0] div_result_i,
    input  logic        div_ready_i,
    output logic        hilo_we_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        div_err_o
);

    localparam int CNT_W = $clog2(MAX_WAIT);

    div_state_e  state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic        start_reg, start_next;
    logic [7:0]  op_reg, op_next;
    logic [31:0] src1_reg, src1_next;
    logic [31:0] src2_reg, src2_next;
    logic [31:0] hi_reg, hi_next;
    logic [31:0] lo_reg, lo_next;
    logic        hilo_we_reg, hilo_we_next;
    logic        err_reg, err_next;
    logic        req;

    // A divide instruction in EX that is not being annulled this cycle
    assign req = ex_valid_i & is_div_op(ex_op_i) & ~flush_i;

    // Next-state logic plus the combinational stall/annul outputs
    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        start_next   = start_reg;
        op_next      = op_reg;
        src1_next    = src1_reg;
        src2_next    = src2_reg;
        hi_next      = hi_reg;
        lo_next      = lo_reg;
        hilo_we_next = 1'b0;
        err_next     = 1'b0;
        stall_req_o  = 1'b0;
        div_annul_o  = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                // Keep outputs quiet while reset is asserted
                stall_req_o = req & rst;
                // A stale ready level would violate the handshake, so wait it out
                if (req && (div_ready_i != DIV_READY)) begin
                    op_next    = ex_op_i;
                    src1_next  = ex_src1_i;
                    src2_next  = ex_src2_i;
                    start_next = DIV_START;
                    cnt_next   = '0;
                    state_next = ST_BUSY;
                end
            end

            ST_BUSY: begin
                stall_req_o = 1'b1;
                if (flush_i) begin
                    // Flush beats a same-cycle ready: no HI/LO write
                    div_annul_o = 1'b1;
                    start_next  = DIV_STOP;
                    cnt_next    = '0;
                    state_next  = ST_CANCEL;
                end else if (div_ready_i == DIV_READY) begin
                    hi_next      = div_result_i[63:32];
                    lo_next      = div_result_i[31:0];
                    hilo_we_next = 1'b1;
                    start_next   = DIV_STOP;
                    state_next   = ST_DONE;
                end else if (cnt_reg == CNT_W'(MAX_WAIT - 1)) begin
                    err_next   = 1'b1;
                    start_next = DIV_STOP;
                    cnt_next   = '0;
                    state_next = ST_CANCEL;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end

            ST_DONE: begin
                // Same instruction may still sit in EX; never reissue it
                if (!stall_i || flush_i) begin
                    state_next = ST_IDLE;
                end
            end

            ST_CANCEL: begin
                // Two-cycle drain of the divider; counter reused as timer
                div_annul_o = 1'b1;
                stall_req_o = req;
                if (cnt_reg == CNT_W'(1)) begin
                    cnt_next   = '0;
                    state_next = ST_IDLE;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State, operand and result registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg   <= ST_IDLE;
            cnt_reg     <= '0;
            start_reg   <= DIV_STOP;
            op_reg      <= '0;
            src1_reg    <= '0;
            src2_reg    <= '0;
            hi_reg      <= '0;
            lo_reg      <= '0;
            hilo_we_reg <= 1'b0;
            err_reg     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            start_reg   <= start_next;
            op_reg      <= op_next;
            src1_reg    <= src1_next;
            src2_reg    <= src2_next;
            hi_reg      <= hi_next;
            lo_reg      <= lo_next;
            hilo_we_reg <= hilo_we_next;
            err_reg     <= err_next;
        end
    end

    assign div_start_o   = start_reg;
    assign div_op_o      = op_reg;
    assign div_opdata1_o = src1_reg;
    assign div_opdata2_o = src2_reg;
    assign hilo_we_o     = hilo_we_reg;
    assign hi_o          = hi_reg;
    assign lo_o          = lo_reg;
    assign div_err_o     = err_reg;

endmodule
